// File: rtl/serial_shift_add_mult_pkg.sv
// Shared definitions for the serial shift-and-add multiplier:
// FSM state encodings and the default operand width.
package serial_mult_pkg;

  localparam int MULT_N = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_shift_add_mult_if.sv
// Request/response bundle of the serial multiplier: operands and start in,
// busy/done status and the 2N-bit product out.
interface serial_shift_add_mult_if
  import serial_mult_pkg::*;
#(
  parameter int N = MULT_N
);

  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/serial_shift_add_mult_cla_adder.sv
// N-bit carry-lookahead adder used by the multiplier's accumulate step.
// Each carry is formed from the generate/propagate terms rather than a ripple chain.
module cla_adder #(
  parameter int N = 8
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  logic         t;

  assign g = in1 & in2;
  assign p = in1 ^ in2;

  // Carry into bit i+1 is the flattened lookahead expression over bits 0..i.
  always_comb begin
    t    = cin;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      t = cin;
      for (int j = 0; j <= i; j++) begin
        t = g[j] | (p[j] & t);
      end
      c[i+1] = t;
    end
  end

  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];

endmodule

// File: rtl/serial_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// fixed N+1 cycle latency from accepted start to the done pulse.
module serial_shift_add_mult
  import serial_mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_shift_add_mult_if.slave bus
);

  localparam int CNT_W = $clog2(N);

  state_t           state;
  logic [N-1:0]     mcand_q;
  logic [2*N-1:0]   acc;
  logic [CNT_W-1:0] count;
  logic [N-1:0]     hi;
  logic [N-1:0]     lo;
  logic [N-1:0]     addend;
  logic [N-1:0]     sum;
  logic             cout;

  assign hi          = acc[2*N-1:N];
  assign lo          = acc[N-1:0];
  assign addend      = lo[0] ? mcand_q : '0;
  assign bus.product = acc;

  cla_adder #(.N(N)) u_cla (
    .in1  (hi),
    .in2  (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // Control and datapath in one register block; the adder carry becomes the
  // new top bit so the shifted accumulator never drops a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      acc      <= '0;
      count    <= '0;
      mcand_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            mcand_q  <= bus.multiplicand;
            acc      <= {{N{1'b0}}, bus.multiplier};
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= {cout, sum, lo[N-1:1]};
          count <= count + 1'b1;
          if (count == CNT_W'(N - 1)) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_add_mult.sv
// Table-driven bench for serial_shift_add_mult (N=8) plus a random N=16
// instance checked against a reference product.
module tb_serial_shift_add_mult;

  logic clk;
  logic rst_n;

  int total_checks;
  int passed_checks;

  serial_shift_add_mult_if #(.N(8))  bus ();
  serial_shift_add_mult_if #(.N(16)) bus16 ();

  serial_shift_add_mult #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  serial_shift_add_mult #(.N(16)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act === exp) begin
      passed_checks++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDone16(output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      if (bus16.done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Start one N=8 operation, scramble the operand inputs after acceptance,
  // and return busy in the first cycle, the done cycle number and the product.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               output logic busy1, output int lat, output logic [15:0] prod);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start        = 1'b0;
    bus.multiplicand = ~a;
    bus.multiplier   = ~b;
    busy1 = bus.busy;
    waitDone(lat);
    prod = bus.product;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        busy1;
    int          lat;
    int          pulses;
    logic [15:0] prod;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [31:0] ref16;

    total_checks  = 0;
    passed_checks = 0;

    vecs[0] = '{8'd3,   8'd5,   16'd15};
    vecs[1] = '{8'd255, 8'd255, 16'd65025};
    vecs[2] = '{8'd0,   8'd200, 16'd0};
    vecs[3] = '{8'd200, 8'd0,   16'd0};
    vecs[4] = '{8'd1,   8'd1,   16'd1};
    vecs[5] = '{8'd17,  8'd9,   16'd153};
    vecs[6] = '{8'd128, 8'd2,   16'd256};
    vecs[7] = '{8'd170, 8'd85,  16'd14450};
    vecs[8] = '{8'd100, 8'd100, 16'd10000};
    vecs[9] = '{8'd15,  8'd17,  16'd255};

    bus.start          = 1'b0;
    bus.multiplicand   = '0;
    bus.multiplier     = '0;
    bus16.start        = 1'b0;
    bus16.multiplicand = '0;
    bus16.multiplier   = '0;
    rst_n              = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy",    32'(bus.busy),    32'd0);
    checkOutput("reset_done",    32'(bus.done),    32'd0);
    checkOutput("reset_product", 32'(bus.product), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, busy1, lat, prod);
      checkOutput($sformatf("vec%0d_busy", i),    32'(busy1), 32'd1);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat),   32'd9);
      checkOutput($sformatf("vec%0d_product", i), 32'(prod),  32'(vecs[i].prod));
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_done_low", i), 32'(bus.done), 32'd0);
      checkOutput($sformatf("vec%0d_busy_low", i), 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_hold", i), 32'(bus.product), 32'(vecs[i].prod));
    end

    // start held high through a whole op, operands changed mid-run
    bus.multiplicand = 8'd6;
    bus.multiplier   = 8'd7;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.multiplicand = 8'd9;
    bus.multiplier   = 8'd11;
    waitDone(lat);
    checkOutput("held_latency", 32'(lat),         32'd9);
    checkOutput("held_product", 32'(bus.product), 32'd42);
    @(posedge clk); #1;
    checkOutput("held_idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("held_idle_done", 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    checkOutput("held_restart_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    waitDone(lat);
    checkOutput("held2_latency", 32'(lat),         32'd9);
    checkOutput("held2_product", 32'(bus.product), 32'd99);
    @(posedge clk); #1;

    // asynchronous reset in the middle of an operation
    bus.multiplicand = 8'd17;
    bus.multiplier   = 8'd9;
    bus.start        = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",    32'(bus.busy),    32'd0);
    checkOutput("midrst_done",    32'(bus.done),    32'd0);
    checkOutput("midrst_product", 32'(bus.product), 32'd0);
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) pulses++;
    end
    checkOutput("midrst_no_done", 32'(pulses), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(8'd17, 8'd9, busy1, lat, prod);
    checkOutput("after_rst_latency", 32'(lat),  32'd9);
    checkOutput("after_rst_product", 32'(prod), 32'd153);
    @(posedge clk); #1;

    // N=16 random pairs against the reference product
    for (int i = 0; i < 150; i++) begin
      if (i == 0) begin
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
      end else begin
        a16 = 16'($urandom);
        b16 = 16'($urandom);
      end
      ref16 = 32'(a16) * 32'(b16);
      bus16.multiplicand = a16;
      bus16.multiplier   = b16;
      bus16.start        = 1'b1;
      @(posedge clk); #1;
      bus16.start        = 1'b0;
      bus16.multiplicand = ~a16;
      bus16.multiplier   = ~b16;
      waitDone16(lat);
      checkOutput($sformatf("n16_%0d_latency", i), 32'(lat),           32'd17);
      checkOutput($sformatf("n16_%0d_product", i), 32'(bus16.product), ref16);
      @(posedge clk); #1;
      checkOutput($sformatf("n16_%0d_done_low", i), 32'(bus16.done),    32'd0);
      checkOutput($sformatf("n16_%0d_hold", i),     32'(bus16.product), ref16);
    end

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
